dac_tx_framer: RTL and testbench
================================

DAC_TX_FRAMER -- requirements
Module: dac_tx_framer

Interface
REQ-001 The block SHALL have parameter DATA_W, default 12, DAC sample width in bits (offset binary).
REQ-002 The block SHALL have parameter NUM_CH, default 2, channels time-multiplexed per frame (>=1).
REQ-003 The block SHALL have parameter FIFO_DEPTH, default 8, sample-frame FIFO depth (power of 2, >=2).
REQ-004 The block SHALL have parameter RAMP_STEP, default 1, ramp increment per frame.
REQ-005 clk  input  1  sole clock; all logic on rising edge.
REQ-006 rst_n  input  1  synchronous, active-low reset.
REQ-007 en  input  1  transmit enable.
REQ-008 mode  input  2  source select: 0 stream, 1 ramp, 2 midscale, 3 zero.
REQ-009 s_valid  input  1  input frame valid.
REQ-010 s_ready  output  1  FIFO can accept a frame.
REQ-011 s_data  input  NUM_CH*DATA_W  one frame; channel c at bits [c*DATA_W +: DATA_W].
REQ-012 tx_data  output  DATA_W  registered sample for current slot.
REQ-013 tx_strobe  output  1  high on the channel-0 slot of each frame.
REQ-014 tx_valid  output  1  tx_data carries framed output.
REQ-015 fifo_level  output  $clog2(FIFO_DEPTH+1)  frames currently stored.
REQ-016 underflow  output  1  sticky stream-underflow flag.
REQ-017 clr_underflow  input  1  clears underflow.

Function
REQ-018 A slot counter SHALL count 0..NUM_CH-1 while en=1 and wrap to 0; held at 0 while en=0.
REQ-019 A frame fetch SHALL occur on each cycle with en=1 and slot=0; mode is sampled only at fetch, so mode changes take effect at the next frame boundary.
REQ-020 Fetch in mode 0 with FIFO non-empty SHALL pop one frame into the frame register; with FIFO empty it SHALL load midscale (1<<(DATA_W-1)) on all channels and set underflow.
REQ-021 Fetch in mode 1 SHALL load the ramp counter value on all channels, then add RAMP_STEP modulo 2^DATA_W.
REQ-022 Fetch in modes 2/3 SHALL load midscale / all-zero on all channels; ramp counter holds.
REQ-023 Output latency SHALL be one cycle: on the cycle after slot s, tx_data = channel s (slot 0 taken directly from the fetched frame), tx_strobe = (s==0), tx_valid = 1.
REQ-024 When en=0, outputs SHALL be tx_data = midscale, tx_strobe = 0, tx_valid = 0 on the following cycle; a partial frame is abandoned, no pop occurs.
REQ-025 FIFO SHALL push when s_valid && s_ready; s_ready = (fifo_level < FIFO_DEPTH), derived from registered state.
REQ-026 Simultaneous push and pop SHALL leave fifo_level unchanged; pointers wrap modulo FIFO_DEPTH.
REQ-027 No bypass: a frame pushed on a fetch cycle with FIFO empty SHALL NOT be consumed by that fetch (underflow still flagged).
REQ-028 FIFO SHALL accept input in every mode and with en=0; pops occur only in mode 0.
REQ-029 underflow SHALL stay set until clr_underflow=1; simultaneous set and clear SHALL leave it set.
REQ-030 With NUM_CH=1 every valid output cycle SHALL have tx_strobe=1.

Reset
REQ-031 While rst_n=0 at a clock edge: tx_data = midscale, tx_strobe = 0, tx_valid = 0, underflow = 0, fifo_level = 0, s_ready = 1, slot = 0, ramp counter = 0, FIFO contents discarded; applies mid-frame identically.
REQ-032 First fetch after reset SHALL occur on the first edge with rst_n=1 and en=1.

Verification
REQ-033 Defaults, mode 0, push frames {ch0=0x123,ch1=0x456},{0x789,0xABC}, then en=1 -> tx_data 0x123,0x456,0x789,0xABC with tx_strobe 1,0,1,0; then 0x800,0x800 and underflow=1.
REQ-034 Mode 1, en=1 for 4 frames -> ramp values 0,0,1,1,2,2,3,3; DATA_W=12 from ramp 0xFFF -> next frame 0x000.
REQ-035 Push 9 frames with en=0 -> s_ready low after 8, fifo_level=8, 9th not accepted; one pop re-asserts s_ready next cycle.
REQ-036 Mode switched 0->2 at slot 1 -> slot-1 sample still from stream frame; next frame 0x800,0x800.
REQ-037 underflow set and clr_underflow=1 on same cycle -> underflow remains 1; clr alone next cycle -> 0.
REQ-038 rst_n=0 mid-frame with fifo_level=3 -> next cycle fifo_level=0, tx_valid=0, tx_data=0x800, s_ready=1.

Source files
------------

// File: rtl/dac_tx_framer.sv
// Sample-frame FIFO feeding a slot-multiplexed DAC output, with ramp, midscale
// and zero test sources selected at each frame boundary.
module dac_tx_framer #(
  parameter int DATA_W     = 12,
  parameter int NUM_CH     = 2,
  parameter int FIFO_DEPTH = 8,
  parameter int RAMP_STEP  = 1
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               en,
  input  logic [1:0]                         mode,
  input  logic                               s_valid,
  output logic                               s_ready,
  input  logic [NUM_CH*DATA_W-1:0]           s_data,
  output logic [DATA_W-1:0]                  tx_data,
  output logic                               tx_strobe,
  output logic                               tx_valid,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_level,
  output logic                               underflow,
  input  logic                               clr_underflow
);

  localparam int SLOT_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int LVL_W  = $clog2(FIFO_DEPTH + 1);
  localparam int FW     = NUM_CH * DATA_W;
  localparam logic [DATA_W-1:0] MID  = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [DATA_W-1:0] STEP = DATA_W'(RAMP_STEP);

  logic [FW-1:0]     mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0]  level_q;
  logic [SLOT_W-1:0] slot_q;
  logic [DATA_W-1:0] ramp_q;
  logic [FW-1:0]     frame_q;
  logic [DATA_W-1:0] tx_data_q;
  logic              tx_strobe_q, tx_valid_q, underflow_q;

  logic [FW-1:0]     mid_frame, ramp_frame, fetch_frame;
  logic [DATA_W-1:0] frame_ch [NUM_CH];
  logic [DATA_W-1:0] tx_data_d;
  logic              fetch, empty, push, pop, starve;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      assign mid_frame[gi*DATA_W +: DATA_W]  = MID;
      assign ramp_frame[gi*DATA_W +: DATA_W] = ramp_q;
      assign frame_ch[gi]                    = frame_q[gi*DATA_W +: DATA_W];
    end
  endgenerate

  assign empty   = (level_q == '0);
  assign s_ready = (level_q < LVL_W'(FIFO_DEPTH));
  assign push    = s_valid && s_ready;
  assign fetch   = en && (slot_q == '0);
  // Pop sees only the pre-edge level, so a same-cycle push is never bypassed.
  assign pop     = fetch && (mode == 2'd0) && !empty;
  assign starve  = fetch && (mode == 2'd0) && empty;

  always_comb begin
    fetch_frame = '0;
    case (mode)
      2'd0:    fetch_frame = empty ? mid_frame : mem[rd_ptr_q];
      2'd1:    fetch_frame = ramp_frame;
      2'd2:    fetch_frame = mid_frame;
      default: fetch_frame = '0;
    endcase
  end

  // Slot 0 is emitted straight from the frame being fetched this cycle.
  assign tx_data_d = (slot_q == '0) ? fetch_frame[DATA_W-1:0] : frame_ch[slot_q];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= s_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      slot_q      <= '0;
      ramp_q      <= '0;
      frame_q     <= '0;
      tx_data_q   <= MID;
      tx_strobe_q <= 1'b0;
      tx_valid_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase

      if (en) begin
        slot_q      <= (slot_q == SLOT_W'(NUM_CH - 1)) ? '0 : slot_q + 1'b1;
        tx_data_q   <= tx_data_d;
        tx_strobe_q <= (slot_q == '0);
        tx_valid_q  <= 1'b1;
        if (fetch) begin
          frame_q <= fetch_frame;
          if (mode == 2'd1) ramp_q <= ramp_q + STEP;
        end
      end else begin
        slot_q      <= '0;
        tx_data_q   <= MID;
        tx_strobe_q <= 1'b0;
        tx_valid_q  <= 1'b0;
      end

      if (starve)             underflow_q <= 1'b1;
      else if (clr_underflow) underflow_q <= 1'b0;
    end
  end

  assign tx_data    = tx_data_q;
  assign tx_strobe  = tx_strobe_q;
  assign tx_valid   = tx_valid_q;
  assign fifo_level = level_q;
  assign underflow  = underflow_q;

endmodule

// File: tb/tb_dac_tx_framer.sv
// Bench for dac_tx_framer: fixed vector table, directed corner sequences and a
// randomized run checked against a queue-based frame model.
module tb_dac_tx_framer;
  localparam int DW    = 12;
  localparam int NCH   = 2;
  localparam int DEPTH = 8;
  localparam logic [DW-1:0] MID = 12'h800;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0, en = 1'b0, s_valid = 1'b0, clr_underflow = 1'b0;
  logic [1:0]      mode = 2'd0;
  logic [NCH*DW-1:0] s_data = '0;
  logic            s_ready, tx_strobe, tx_valid, underflow;
  logic [DW-1:0]   tx_data;
  logic [3:0]      fifo_level;

  int vectors = 0;
  int miscompares = 0;

  dac_tx_framer dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .s_valid(s_valid),
    .s_ready(s_ready), .s_data(s_data), .tx_data(tx_data), .tx_strobe(tx_strobe),
    .tx_valid(tx_valid), .fifo_level(fifo_level), .underflow(underflow),
    .clr_underflow(clr_underflow)
  );

  always #5 clk = ~clk;

  // Behavioural model: frames held in a queue, one current frame, a slot index.
  logic [NCH*DW-1:0] mq[$];
  logic [NCH*DW-1:0] cur;
  int      ramp, slot;
  bit      m_uf, m_strobe, m_valid;
  logic [DW-1:0] m_data;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    bit do_push, set_uf;
    logic [DW-1:0] r;
    if (!rst_n) begin
      mq.delete(); ramp = 0; m_uf = 0; slot = 0; cur = '0;
      m_data = MID; m_strobe = 0; m_valid = 0;
    end else begin
      do_push = s_valid && (mq.size() < DEPTH);
      set_uf  = 0;
      if (en) begin
        if (slot == 0) begin
          case (mode)
            2'd0: if (mq.size() > 0) cur = mq.pop_front();
                  else begin cur = {NCH{MID}}; set_uf = 1; end
            2'd1: begin r = ramp[DW-1:0]; cur = {NCH{r}}; ramp = (ramp + 1) % (1 << DW); end
            2'd2: cur = {NCH{MID}};
            default: cur = '0;
          endcase
        end
        m_data = cur[slot*DW +: DW];
        m_strobe = (slot == 0); m_valid = 1;
        slot = (slot + 1) % NCH;
      end else begin
        m_data = MID; m_strobe = 0; m_valid = 0; slot = 0;
      end
      if (set_uf) m_uf = 1;
      else if (clr_underflow) m_uf = 0;
      if (do_push) mq.push_back(s_data);
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk); #1;
    chk("tx_data", int'(tx_data), int'(m_data));
    chk("tx_strobe", int'(tx_strobe), int'(m_strobe));
    chk("tx_valid", int'(tx_valid), int'(m_valid));
    chk("fifo_level", int'(fifo_level), mq.size());
    chk("underflow", int'(underflow), int'(m_uf));
    chk("s_ready", int'(s_ready), int'(mq.size() < DEPTH));
  endtask

  task automatic do_reset();
    rst_n = 0; en = 0; s_valid = 0; clr_underflow = 0; mode = 0;
    step();
    rst_n = 1;
  endtask

  typedef struct {
    logic rst_n, en; logic [1:0] mode; logic s_valid; logic [NCH*DW-1:0] s_data; logic clr;
    logic [DW-1:0] e_data; logic e_strobe, e_valid; int e_level; logic e_uf;
  } vec_t;
  vec_t tbl[13];

  function automatic vec_t mk(logic r, logic e, logic [1:0] m, logic v, logic [NCH*DW-1:0] d,
                              logic c, logic [DW-1:0] ed, logic es, logic ev, int el, logic eu);
    vec_t t;
    t.rst_n = r; t.en = e; t.mode = m; t.s_valid = v; t.s_data = d; t.clr = c;
    t.e_data = ed; t.e_strobe = es; t.e_valid = ev; t.e_level = el; t.e_uf = eu;
    return t;
  endfunction

  initial begin
    bit found;
    logic [NCH*DW-1:0] rnd;

    tbl[0]  = mk(0, 0, 0, 0, 24'h0,      0, MID,    0, 0, 0, 0);
    tbl[1]  = mk(1, 0, 0, 1, 24'h456123, 0, MID,    0, 0, 1, 0);
    tbl[2]  = mk(1, 0, 0, 1, 24'hABC789, 0, MID,    0, 0, 2, 0);
    tbl[3]  = mk(1, 1, 0, 0, 24'h0,      0, 12'h123, 1, 1, 1, 0);
    tbl[4]  = mk(1, 1, 0, 0, 24'h0,      0, 12'h456, 0, 1, 1, 0);
    tbl[5]  = mk(1, 1, 0, 0, 24'h0,      0, 12'h789, 1, 1, 0, 0);
    tbl[6]  = mk(1, 1, 0, 0, 24'h0,      0, 12'hABC, 0, 1, 0, 0);
    tbl[7]  = mk(1, 1, 0, 0, 24'h0,      0, MID,    1, 1, 0, 1);
    tbl[8]  = mk(1, 1, 0, 0, 24'h0,      0, MID,    0, 1, 0, 1);
    tbl[9]  = mk(1, 0, 0, 0, 24'h0,      1, MID,    0, 0, 0, 0);
    tbl[10] = mk(1, 1, 0, 0, 24'h0,      1, MID,    1, 1, 0, 1);
    tbl[11] = mk(1, 0, 0, 0, 24'h0,      1, MID,    0, 0, 0, 0);
    tbl[12] = mk(1, 0, 0, 0, 24'h0,      0, MID,    0, 0, 0, 0);

    for (int i = 0; i < 13; i++) begin
      rst_n = tbl[i].rst_n; en = tbl[i].en; mode = tbl[i].mode;
      s_valid = tbl[i].s_valid; s_data = tbl[i].s_data; clr_underflow = tbl[i].clr;
      step();
      chk($sformatf("tbl%0d_data", i), int'(tx_data), int'(tbl[i].e_data));
      chk($sformatf("tbl%0d_strobe", i), int'(tx_strobe), int'(tbl[i].e_strobe));
      chk($sformatf("tbl%0d_valid", i), int'(tx_valid), int'(tbl[i].e_valid));
      chk($sformatf("tbl%0d_level", i), int'(fifo_level), tbl[i].e_level);
      chk($sformatf("tbl%0d_uf", i), int'(underflow), int'(tbl[i].e_uf));
      $display("vec %0d: tx_data=%h strobe=%b valid=%b level=%0d uf=%b", i,
               tx_data, tx_strobe, tx_valid, fifo_level, underflow);
    end

    // Ramp: 0,0,1,1,2,2,3,3 then run on to the 0xFFF -> 0x000 wrap.
    do_reset();
    en = 1; mode = 2'd1;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("ramp_val", int'(tx_data), i / 2);
      chk("ramp_strobe", int'(tx_strobe), int'(i % 2 == 0));
    end
    found = 0;
    for (int i = 0; i < 9000 && !found; i++) begin
      step();
      if (tx_strobe && tx_data == 12'hFFF) found = 1;
    end
    chk("ramp_reach_fff", int'(found), 1);
    step(); step();
    chk("ramp_wrap", int'(tx_data), 0);
    chk("ramp_wrap_strobe", int'(tx_strobe), 1);
    $display("ramp wrap: tx_data=%h", tx_data);

    // FIFO full: 9 pushes with en=0, one pop frees a slot.
    do_reset();
    s_valid = 1;
    for (int i = 0; i < 9; i++) begin
      s_data = {12'(i + 16'h10), 12'(i)};
      step();
      if (i >= 7) begin
        chk("full_level", int'(fifo_level), 8);
        chk("full_ready", int'(s_ready), 0);
      end
    end
    s_valid = 0; en = 1; mode = 2'd0;
    step();
    chk("full_pop_data", int'(tx_data), 0);
    chk("full_pop_level", int'(fifo_level), 7);
    chk("full_pop_ready", int'(s_ready), 1);
    en = 0;
    $display("fifo full: level after pop=%0d ready=%b", fifo_level, s_ready);

    // Mode 0 -> 2 at slot 1.
    do_reset();
    s_valid = 1; s_data = 24'h456123;
    step();
    s_valid = 0; en = 1; mode = 2'd0;
    step();
    chk("msw_s0", int'(tx_data), 12'h123);
    mode = 2'd2;
    step();
    chk("msw_s1", int'(tx_data), 12'h456);
    step();
    chk("msw_mid0", int'(tx_data), int'(MID));
    chk("msw_mid0_strobe", int'(tx_strobe), 1);
    step();
    chk("msw_mid1", int'(tx_data), int'(MID));
    en = 0;
    $display("mode switch: last tx_data=%h", tx_data);

    // Reset mid-frame with three frames stored.
    do_reset();
    s_valid = 1;
    for (int i = 0; i < 3; i++) begin s_data = 24'(32'hA0B0 + i); step(); end
    s_valid = 0; en = 1; mode = 2'd2;
    step();
    chk("mrst_level_pre", int'(fifo_level), 3);
    rst_n = 0;
    step();
    chk("mrst_level", int'(fifo_level), 0);
    chk("mrst_valid", int'(tx_valid), 0);
    chk("mrst_data", int'(tx_data), int'(MID));
    chk("mrst_ready", int'(s_ready), 1);
    rst_n = 1; en = 0;
    $display("mid-frame reset: level=%0d valid=%b data=%h", fifo_level, tx_valid, tx_data);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      rst_n = ($urandom_range(0, 199) != 0);
      en = ($urandom_range(0, 9) < 8);
      mode = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
      s_valid = ($urandom_range(0, 1) == 1);
      rnd = 24'($urandom);
      s_data = rnd;
      clr_underflow = ($urandom_range(0, 9) == 0);
      step();
    end
    $display("random: done, level=%0d uf=%b", fifo_level, underflow);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
